pwm_bridge_drv: RTL and testbench
=================================

Name: pwm_bridge_drv

Overview:
- Downstream stage of the velocity data-processing block.
- Consumes the clamped magnitude (0..2500) and direction bit and produces the two H-bridge gate inputs for one wheel motor.
- Generates edge-aligned PWM from a free-running period counter, with shadowed duty and direction updates at period boundaries.
- Inserts a dead interval on every direction reversal and on enable, so both bridge legs are never driven in the same cycle.

Parameters:
- PERIOD, 2500: PWM period in clk cycles; equals the upstream magnitude limit, so duty 2500 = 100 %.
- DEAD_CYCLES, 50: number of cycles both outputs are held low on a direction change or on enable.
- CNT_W, 12: width of the period and dead counters; must satisfy 2^CNT_W > PERIOD and 2^CNT_W > DEAD_CYCLES.

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  reset, synchronous, active-low.
- enable  in  1  drive enable; 0 forces coast.
- duty  in  32  unsigned duty in clocks, from the upstream magnitude output.
- dir  in  1  requested direction from upstream: 0 = forward, 1 = reverse.
- in1  out  1  bridge leg A; active in forward.
- in2  out  1  bridge leg B; active in reverse.
- period_start  out  1  one-cycle pulse at the first cycle of each RUN period.
- dir_act  out  1  direction currently applied to the bridge.

Behaviour:
- Reset (rst_n low at a clk edge):
  - state = IDLE; cnt = 0; dead_cnt = 0; duty_sh = 0; dir_act = 0.
  - in1 = 0; in2 = 0; period_start = 0.
  - Reset asserted mid-period or mid-DEAD aborts immediately; outputs are low from the next edge.
- States: IDLE, DEAD, RUN. All outputs are registered.
- IDLE:
  - in1 = in2 = 0; cnt = 0.
  - On enable = 1: go to DEAD; dir_act <= dir; dead_cnt <= 0.
- DEAD:
  - in1 = in2 = 0; dead_cnt increments each cycle.
  - When dead_cnt = DEAD_CYCLES-1: go to RUN; cnt <= 0; duty_sh <= clamp(duty).
  - DEAD therefore lasts exactly DEAD_CYCLES cycles.
- RUN:
  - cnt counts 0..PERIOD-1, then wraps to 0.
  - pwm = (cnt < duty_sh).
  - Registered outputs: in1 <= pwm & ~dir_act; in2 <= pwm & dir_act. Latency is one cycle from cnt to outputs.
  - period_start <= (cnt = 0), so it is high during the cycle in which the outputs reflect cnt = 0.
- Period boundary (cnt = PERIOD-1):
  - If dir = dir_act: cnt <= 0; duty_sh <= clamp(duty).
  - If dir ≠ dir_act: go to DEAD; dir_act <= dir; dead_cnt <= 0.
- Mid-period changes of duty or dir are ignored until the boundary (glitch-free).
- clamp(duty): duty > PERIOD → PERIOD, otherwise duty; 32-bit unsigned compare.
  - duty = 0 → outputs constantly low.
  - duty ≥ PERIOD → the active leg is constantly high.
- enable = 0 in any state: go to IDLE at the next edge; outputs are 0 from that edge.
  - enable has priority over the boundary and DEAD logic.
- Simultaneous enable fall and dir change: IDLE wins.
- Re-enable always passes through DEAD.

Optional Feature:
- Macro: PWM_BRAKE_EN.
- Defined:
  - In RUN with duty_sh = 0, in1 = in2 = 1 (short brake) for the whole period.
  - The first and last period before any DEAD entry use coast instead, so a brake never abuts the opposite leg.
  - IDLE and DEAD remain coast.
- Undefined: duty_sh = 0 gives in1 = in2 = 0 (coast); no state ever drives both legs high.

Decomposition:
- Shared package motor_pkg: state encoding constants (IDLE, DEAD, RUN), PWM_PERIOD_DEF = 2500, DEAD_CYCLES_DEF = 50.
- The upstream limit constant also comes from PWM_PERIOD_DEF, so both stages stay consistent.
- One natural sub-module: pwm_counter, holding the period counter, the wrap and boundary flag, and the comparator.
- The FSM, shadow registers and leg steering stay in the top level.

Test Plan:
- Reset with enable = 1, dir = 0, duty = 1250, then release → outputs low for 50 cycles; then each 2500-cycle period has in1 high 1250 cycles and in2 = 0; period_start pulses every 2500 cycles.
- duty = 3000 → clamped; in1 high for all 2500 cycles. duty = 0 → in1 = in2 = 0 (brake variant: both 1 after the first period).
- dir toggled 0→1 mid-period at duty = 500 → current period finishes forward; 50 cycles low; then in2 high 500 of 2500; in1 and in2 never both 1.
- duty changed 500→2000 at cnt = 100 → current period still high for 500; the next period is high for 2000.
- enable dropped at cnt = 300 while the output is high → outputs low at the next edge; re-enable → 50-cycle DEAD, then cnt restarts at 0.
- rst_n pulsed low for 1 cycle during DEAD → state IDLE, dir_act = 0, outputs 0; with enable still high, a full 50-cycle DEAD is re-run.

Source files
------------

// File: rtl/motor_pkg.sv
// rtl/motor_pkg.sv - shared motor-drive constants and state encoding
package motor_pkg;

    localparam int PWM_PERIOD_DEF  = 2500;
    localparam int DEAD_CYCLES_DEF = 50;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DEAD = 2'd1,
        ST_RUN  = 2'd2
    } drv_state_t;

endpackage

// File: rtl/pwm_counter.sv
// rtl/pwm_counter.sv - free-running PWM period counter with boundary flag and duty comparator
module pwm_counter
    import motor_pkg::*;
#(
    parameter int PERIOD = PWM_PERIOD_DEF,
    parameter int CNT_W  = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [CNT_W-1:0] duty_sh,
    output logic [CNT_W-1:0] cnt,
    output logic             boundary,
    output logic             pwm
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

    assign boundary = (cnt == CNT_LAST);
    assign pwm      = (cnt < duty_sh);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || boundary) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pwm_bridge_drv.sv
// rtl/pwm_bridge_drv.sv - H-bridge PWM driver with dead time; PWM_BRAKE_EN enables short-brake at zero duty
module pwm_bridge_drv
    import motor_pkg::*;
#(
    parameter int PERIOD      = PWM_PERIOD_DEF,
    parameter int DEAD_CYCLES = DEAD_CYCLES_DEF,
    parameter int CNT_W       = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [31:0] duty,
    input  logic        dir,
    output logic        in1,
    output logic        in2,
    output logic        period_start,
    output logic        dir_act
);

    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);
    localparam logic [31:0]      PERIOD_32 = 32'(PERIOD);

    drv_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] dead_cnt;
    logic [CNT_W-1:0] duty_sh;
    logic [CNT_W-1:0] duty_clamped;
    logic             boundary;
    logic             pwm;
    logic             run_act;
    logic             load_dir;
    logic             load_duty;
    logic             dead_clr;
    logic             leg_a;
    logic             leg_b;

    assign duty_clamped = (duty > PERIOD_32) ? CNT_W'(PERIOD) : duty[CNT_W-1:0];
    assign run_act      = (state == ST_RUN) && enable;

    pwm_counter #(
        .PERIOD (PERIOD),
        .CNT_W  (CNT_W)
    ) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (!run_act),
        .duty_sh  (duty_sh),
        .cnt      (cnt),
        .boundary (boundary),
        .pwm      (pwm)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Dropping enable overrides everything, including a pending boundary or dead-time exit.
    always_comb begin
        state_nxt = state;
        load_dir  = 1'b0;
        load_duty = 1'b0;
        dead_clr  = 1'b0;
        if (!enable) begin
            state_nxt = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    state_nxt = ST_DEAD;
                    load_dir  = 1'b1;
                    dead_clr  = 1'b1;
                end
                ST_DEAD: begin
                    if (dead_cnt == DEAD_LAST) begin
                        state_nxt = ST_RUN;
                        load_duty = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (boundary) begin
                        if (dir != dir_act) begin
                            state_nxt = ST_DEAD;
                            load_dir  = 1'b1;
                            dead_clr  = 1'b1;
                        end else begin
                            load_duty = 1'b1;
                        end
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

`ifdef PWM_BRAKE_EN
    logic first_per;
    logic brake;

    // Brake is withheld in the first period after dead time and as soon as a reversal is pending.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            first_per <= 1'b0;
        end else if (state == ST_DEAD && state_nxt == ST_RUN) begin
            first_per <= 1'b1;
        end else if (run_act && boundary) begin
            first_per <= 1'b0;
        end
    end

    assign brake = run_act && (duty_sh == '0) && !first_per && (dir == dir_act);
    assign leg_a = (run_act & pwm & ~dir_act) | brake;
    assign leg_b = (run_act & pwm &  dir_act) | brake;
`else
    assign leg_a = run_act & pwm & ~dir_act;
    assign leg_b = run_act & pwm &  dir_act;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dead_cnt     <= '0;
            duty_sh      <= '0;
            dir_act      <= 1'b0;
            in1          <= 1'b0;
            in2          <= 1'b0;
            period_start <= 1'b0;
        end else begin
            if (dead_clr) begin
                dead_cnt <= '0;
            end else if (state == ST_DEAD) begin
                dead_cnt <= dead_cnt + CNT_W'(1);
            end
            if (load_duty) begin
                duty_sh <= duty_clamped;
            end
            if (load_dir) begin
                dir_act <= dir;
            end
            in1          <= leg_a;
            in2          <= leg_b;
            period_start <= run_act && (cnt == '0);
        end
    end

endmodule

// File: tb/tb_pwm_bridge_drv.sv
// tb/tb_pwm_bridge_drv.sv - directed self-checking bench for pwm_bridge_drv
module tb_pwm_bridge_drv;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [31:0] duty;
    logic        dir;
    logic        in1;
    logic        in2;
    logic        period_start;
    logic        dir_act;

    int checks   = 0;
    int failures = 0;
    int c1, c2, cps, both_cnt;
    int ca, cb;
    logic fps;

    always #5 clk = ~clk;

    pwm_bridge_drv dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .duty         (duty),
        .dir          (dir),
        .in1          (in1),
        .in2          (in2),
        .period_start (period_start),
        .dir_act      (dir_act)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance n cycles, sampling 1 time unit after each edge.
    task automatic measure(input int n);
        c1 = 0; c2 = 0; cps = 0; fps = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (i == 0) fps = period_start;
            c1  += int'(in1);
            c2  += int'(in2);
            cps += int'(period_start);
            both_cnt += int'(in1 & in2);
        end
    endtask

    initial begin
        both_cnt = 0;
        rst_n  = 1'b0;
        enable = 1'b1;
        dir    = 1'b0;
        duty   = 32'd1250;
        measure(3);
        check("rst_in1", int'(in1), 0);
        check("rst_in2", int'(in2), 0);
        check("rst_ps", int'(period_start), 0);
        check("rst_dir_act", int'(dir_act), 0);

        rst_n = 1'b1;
        measure(51);
        check("startup_dead_legs", c1 + c2, 0);
        measure(2500);
        check("p0_first_ps", int'(fps), 1);
        check("p0_in1", c1, 1250);
        check("p0_in2", c2, 0);
        check("p0_ps_count", cps, 1);

        duty = 32'd3000;
        measure(2500);
        check("p1_shadowed_in1", c1, 1250);
        check("p1_first_ps", int'(fps), 1);

        duty = 32'd0;
        measure(2500);
        check("p2_clamped_in1", c1, 2500);
        check("p2_ps_count", cps, 1);

        duty = 32'd500;
        measure(2500);
`ifdef PWM_BRAKE_EN
        check("p3_zero_in1", c1, 2500);
        check("p3_zero_in2", c2, 2500);
`else
        check("p3_zero_in1", c1, 0);
        check("p3_zero_in2", c2, 0);
`endif

        measure(1000);
        ca = c1;
        dir = 1'b1;
        measure(1000);
        check("p4_dir_act_held", int'(dir_act), 0);
        ca += c1;
        cb = c2;
        measure(500);
        check("p4_in1_finishes_fwd", ca + c1, 500);
        check("p4_in2", cb + c2, 0);
        measure(50);
        check("rev_dead_legs", c1 + c2, 0);
        check("rev_dir_act", int'(dir_act), 1);
        measure(2500);
        check("p5_first_ps", int'(fps), 1);
        check("p5_in2", c2, 500);
        check("p5_in1", c1, 0);

        measure(100);
        ca = c2;
        duty = 32'd2000;
        measure(2400);
        check("p6_duty_shadowed", ca + c2, 500);
        measure(2500);
        check("p7_new_duty", c2, 2000);
        check("p7_first_ps", int'(fps), 1);

        measure(300);
        check("p8_in2_high", int'(in2), 1);
        enable = 1'b0;
        measure(1);
        check("dis_in2_low", int'(in2), 0);
        check("dis_in1_low", int'(in1), 0);
        measure(4);
        check("idle_legs", c1 + c2, 0);
        enable = 1'b1;
        measure(51);
        check("reen_dead_legs", c1 + c2, 0);
        measure(2500);
        check("reen_first_ps", int'(fps), 1);
        check("reen_in2", c2, 2000);
        check("reen_in1", c1, 0);

        enable = 1'b0;
        measure(2);
        enable = 1'b1;
        measure(21);
        check("dead_legs_before_rst", c1 + c2, 0);
        rst_n = 1'b0;
        measure(1);
        check("midrst_dir_act", int'(dir_act), 0);
        check("midrst_in2", int'(in2), 0);
        check("midrst_in1", int'(in1), 0);
        rst_n = 1'b1;
        measure(51);
        check("rerun_dead_legs", c1 + c2, 0);
        measure(1);
        check("rerun_ps", int'(period_start), 1);
        check("rerun_in2", int'(in2), 1);
        check("rerun_dir_act", int'(dir_act), 1);

`ifdef PWM_BRAKE_EN
        check("both_legs_high_cycles", both_cnt, 2500);
`else
        check("both_legs_high_cycles", both_cnt, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
